// File: rtl/nn_pkg.sv
// +----------------------------------------------------------------------------+
// | Package : nn_pkg                                                           |
// | Brief   : Shared constants, state type and helpers for the neural-network  |
// |           datapath blocks.                                                 |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package nn_pkg;

    // Default width of one neuron output / one link word
    localparam int c_DATA_W = 8;

    // Output serializer control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } ser_state_t;

    // Number of words in one transmitted frame (optional trailing checksum)
    function automatic int frame_len(input int n_out, input bit cks_en);
        return cks_en ? (n_out + 1) : n_out;
    endfunction

endpackage

`default_nettype wire

// File: rtl/network_output_serializer.sv
// +----------------------------------------------------------------------------+
// | Module  : network_output_serializer                                        |
// | Brief   : Captures N_OUT final-layer neuron outputs on a strobe and streams |
// |           them over a valid/ready link, highest neuron first.              |
// |           Optional macro NW_OUT_CHECKSUM_EN appends an XOR checksum word.  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module network_output_serializer
    import nn_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int N_OUT  = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    capture_i,
    input  logic [N_OUT*DATA_W-1:0] neuron_out_i,
    output logic [DATA_W-1:0]       tx_data_o,
    output logic                    tx_valid_o,
    input  logic                    tx_ready_i,
    output logic                    tx_last_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    drop_o
);

`ifdef NW_OUT_CHECKSUM_EN
    localparam bit c_CKS_EN = 1'b1;
`else
    localparam bit c_CKS_EN = 1'b0;
`endif

    localparam int                 c_FRAME_LEN = frame_len(N_OUT, c_CKS_EN);
    localparam int                 c_IDX_W     = $clog2(N_OUT + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(c_FRAME_LEN - 1);

    ser_state_t                r_state;
    ser_state_t                w_state_nxt;
    logic [c_IDX_W-1:0]        r_idx;
    logic [N_OUT*DATA_W-1:0]   r_buf;
    logic [DATA_W-1:0]         r_tx_data;
    logic                      w_load;
    logic                      w_hs;
    logic [c_IDX_W-1:0]        w_next_idx;
    logic [DATA_W-1:0]         w_next_word;

`ifdef NW_OUT_CHECKSUM_EN
    logic [DATA_W-1:0]         w_cks;

    // XOR of every captured word, sent as the trailing frame word
    always_comb begin
        w_cks = '0;
        for (int k = 0; k < N_OUT; k++) begin
            w_cks = w_cks ^ r_buf[k*DATA_W +: DATA_W];
        end
    end
`endif

    // Word presented after the current one: word i carries neuron N_OUT-1-i
    always_comb begin
        w_next_idx  = r_idx + c_IDX_W'(1);
        w_next_word = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (w_next_idx == c_IDX_W'(k)) begin
                w_next_word = r_buf[(N_OUT-1-k)*DATA_W +: DATA_W];
            end
        end
`ifdef NW_OUT_CHECKSUM_EN
        if (w_next_idx == c_IDX_W'(N_OUT)) begin
            w_next_word = w_cks;
        end
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and link/status outputs; a capture while busy is reported and ignored
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_hs        = 1'b0;
        tx_valid_o  = 1'b0;
        tx_last_o   = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            IDLE: begin
                if (capture_i) begin
                    w_load      = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                tx_valid_o = 1'b1;
                busy_o     = 1'b1;
                tx_last_o  = (r_idx == c_LAST_IDX);
                w_hs       = tx_ready_i;
                if (w_hs && tx_last_o) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy_o      = 1'b1;
                done_o      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        drop_o = capture_i && busy_o;
    end

    // Capture buffer, word index and output word; data holds when not advancing
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_buf     <= '0;
            r_idx     <= '0;
            r_tx_data <= '0;
        end else if (w_load) begin
            r_buf     <= neuron_out_i;
            r_idx     <= '0;
            r_tx_data <= neuron_out_i[(N_OUT-1)*DATA_W +: DATA_W];
        end else if (w_hs && !tx_last_o) begin
            r_idx     <= w_next_idx;
            r_tx_data <= w_next_word;
        end
    end

    assign tx_data_o = r_tx_data;

endmodule

`default_nettype wire

// File: tb/tb_network_output_serializer.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_network_output_serializer                                     |
// | Brief   : Self-checking bench for network_output_serializer with a         |
// |           queue-based frame model. Honours NW_OUT_CHECKSUM_EN if defined.  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_network_output_serializer;

    localparam int DW = 8;
    localparam int N  = 4;

    logic            clk;
    logic            rstn;
    logic            capture_i;
    logic [N*DW-1:0] neuron_out_i;
    logic [DW-1:0]   tx_data_o;
    logic            tx_valid_o;
    logic            tx_ready_i;
    logic            tx_last_o;
    logic            busy_o;
    logic            done_o;
    logic            drop_o;

    int n_checks;
    int n_errors;

    // Reference model: words still to send, "in DONE" flag, last word shown
    logic [DW-1:0] m_q[$];
    bit            m_done;
    logic [DW-1:0] m_last;

    network_output_serializer #(.DATA_W(DW), .N_OUT(N)) u_dut (
        .clk          (clk),
        .rstn         (rstn),
        .capture_i    (capture_i),
        .neuron_out_i (neuron_out_i),
        .tx_data_o    (tx_data_o),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready_i),
        .tx_last_o    (tx_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .drop_o       (drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model
    task automatic cycle(input bit cap, input bit rdy, input logic [N*DW-1:0] nin);
        bit            valid;
        bit            busy;
        logic [DW-1:0] cks;
        @(negedge clk);
        capture_i    = cap;
        tx_ready_i   = rdy;
        neuron_out_i = nin;
        #1;
        valid = (m_q.size() > 0);
        busy  = valid || m_done;
        chk("valid", {31'd0, tx_valid_o}, {31'd0, valid});
        chk("data",  {24'd0, tx_data_o},  {24'd0, valid ? m_q[0] : m_last});
        chk("last",  {31'd0, tx_last_o},  {31'd0, valid && (m_q.size() == 1)});
        chk("busy",  {31'd0, busy_o},     {31'd0, busy});
        chk("done",  {31'd0, done_o},     {31'd0, m_done});
        chk("drop",  {31'd0, drop_o},     {31'd0, cap && busy});
        if (m_done) begin
            m_done = 1'b0;
        end else if (valid) begin
            if (rdy) begin
                m_last = m_q.pop_front();
                if (m_q.size() == 0) m_done = 1'b1;
            end
        end else if (cap) begin
            cks = '0;
            for (int k = N - 1; k >= 0; k--) begin
                m_q.push_back(nin[k*DW +: DW]);
                cks = cks ^ nin[k*DW +: DW];
            end
`ifdef NW_OUT_CHECKSUM_EN
            m_q.push_back(cks);
`endif
            m_last = m_q[0];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn       = 1'b0;
        capture_i  = 1'b0;
        tx_ready_i = 1'b0;
        @(negedge clk);
        rstn   = 1'b1;
        m_q.delete();
        m_done = 1'b0;
        m_last = '0;
    endtask

    initial begin
        logic [N*DW-1:0] d;
        n_checks     = 0;
        n_errors     = 0;
        rstn         = 1'b0;
        capture_i    = 1'b0;
        tx_ready_i   = 1'b0;
        neuron_out_i = '0;
        m_done       = 1'b0;
        m_last       = '0;
        d            = 32'h4433_2211;

        // Reset state
        do_reset();
        cycle(0, 0, d);

        // Single capture, ready held high: 0x44,0x33,0x22,0x11 then done
        cycle(1, 1, d);
        for (int i = 0; i < 8; i++) cycle(0, 1, d);

        // Ready toggling each cycle
        cycle(1, 0, d);
        for (int i = 0; i < 14; i++) cycle(0, i[0], d);

        // Capture mid-frame is dropped, frame unaffected
        cycle(1, 1, d);
        cycle(0, 1, d);
        cycle(1, 1, 32'hDEAD_BEEF);
        for (int i = 0; i < 6; i++) cycle(0, 1, d);

        // Reset after the second transfer, then a fresh frame
        cycle(1, 1, d);
        cycle(0, 1, d);
        cycle(0, 1, d);
        do_reset();
        cycle(0, 1, d);
        cycle(1, 1, d);
        for (int i = 0; i < 7; i++) cycle(0, 1, d);

        // Capture held high: dropped while busy, accepted in IDLE right after DONE
        for (int i = 0; i < 16; i++) cycle(1, 1, d ^ {4{i[7:0]}});
        for (int i = 0; i < 8; i++) cycle(0, 1, d);

        // Randomized traffic with changing neuron data
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1, $urandom());
        end
        for (int i = 0; i < 12; i++) cycle(0, 1, d);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
